// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - SID register map addresses, voice layout and bus FSM types
package sid_pkg;

  localparam logic [4:0] REG_V1_FREQ_LO = 5'h00;
  localparam logic [4:0] REG_V1_FREQ_HI = 5'h01;
  localparam logic [4:0] REG_V1_PW_LO   = 5'h02;
  localparam logic [4:0] REG_V1_PW_HI   = 5'h03;
  localparam logic [4:0] REG_V1_CONTROL = 5'h04;
  localparam logic [4:0] REG_V1_AD      = 5'h05;
  localparam logic [4:0] REG_V1_SR      = 5'h06;
  localparam logic [4:0] REG_FC_LO      = 5'h15;
  localparam logic [4:0] REG_FC_HI      = 5'h16;
  localparam logic [4:0] REG_RES_FILT   = 5'h17;
  localparam logic [4:0] REG_MODE_VOL   = 5'h18;
  localparam logic [4:0] REG_POTX       = 5'h19;
  localparam logic [4:0] REG_POTY       = 5'h1A;
  localparam logic [4:0] REG_OSC3       = 5'h1B;
  localparam logic [4:0] REG_ENV3       = 5'h1C;

  localparam int VOICE_STRIDE = 7;
  localparam int NUM_VOICES   = 3;
  localparam int NUM_FILT     = 4;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [7:0]  control;
    logic [7:0]  ad;
    logic [7:0]  sr;
  } voice_regs_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    COMMIT = ST_COMMIT
  } bus_state_e;

  // Only the low nibble of PW_HI is stored; the pulse width is 12 bits.
  function automatic voice_regs_t voice_write(voice_regs_t r, logic [2:0] off, logic [7:0] d);
    voice_regs_t n;
    n = r;
    case (off)
      3'(REG_V1_FREQ_LO): n.freq[7:0]  = d;
      3'(REG_V1_FREQ_HI): n.freq[15:8] = d;
      3'(REG_V1_PW_LO):   n.pw[7:0]    = d;
      3'(REG_V1_PW_HI):   n.pw[11:8]   = d[3:0];
      3'(REG_V1_CONTROL): n.control    = d;
      3'(REG_V1_AD):      n.ad         = d;
      3'(REG_V1_SR):      n.sr         = d;
      default:            n            = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sid_bus_sync.sv
// rtl/sid_bus_sync.sv - multi-flop synchronizer for the async bus strobes
// valid rises once the chain has been refilled with real pin samples after reset.
module sid_bus_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0]  chain [STAGES];
  logic [STAGES-1:0] fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      fill <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      fill <= {fill[STAGES-2:0], 1'b1};
    end
  end

  assign q     = chain[STAGES-1];
  assign valid = fill[STAGES-1];

endmodule

// File: rtl/sid_bus_regs.sv
// rtl/sid_bus_regs.sv - 6502-bus register front end for the SID voices and filter
// Optional readback decay latch: SID_READBACK_DECAY_EN.
module sid_bus_regs
  import sid_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef SID_READBACK_DECAY_EN
  , parameter int DECAY_CYCLES = 1000000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  phi2,
  input  logic                  cs_n,
  input  logic                  rw,
  input  logic [4:0]            addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic [2:0][15:0]      freq,
  output logic [2:0][11:0]      pw,
  output logic [2:0][7:0]       control,
  output logic [2:0][15:0]      adsr,
  output logic [2:0]            ctrl_wr_stb,
  output logic [3:0][7:0]       filt,
  input  logic [7:0]            osc3,
  input  logic [7:0]            env3,
  input  logic [7:0]            potx,
  input  logic [7:0]            poty
);

  logic [2:0] sync_q;
  logic       sync_valid;
  logic       s_phi2, s_cs_n, s_rw;

  sid_bus_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     ({phi2, cs_n, rw}),
    .q     (sync_q),
    .valid (sync_valid)
  );

  assign s_phi2 = sync_q[2];
  assign s_cs_n = sync_q[1];
  assign s_rw   = sync_q[0];

  bus_state_e state;
  logic       phi2_q, armed, rw_lat;
  logic [4:0] addr_q;
  logic [7:0] data_q;
  logic       phi2_rise, phi2_fall, commit_wr;

  // armed blocks a phi2 that was already high across reset from looking like a fresh rise.
  assign phi2_rise = armed & s_phi2 & ~phi2_q;
  assign phi2_fall = ~s_phi2 & phi2_q;
  assign commit_wr = (state == COMMIT) & ~rw_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      phi2_q <= 1'b0;
      armed  <= 1'b0;
      rw_lat <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      phi2_q <= s_phi2;
      armed  <= armed | (sync_valid & ~s_phi2);
      if (s_phi2) begin
        addr_q <= addr;
        data_q <= data_in;
      end
      if (state == ACCESS) rw_lat <= s_rw;
      case (state)
        IDLE:    if (phi2_rise && !s_cs_n) state <= ACCESS;
        ACCESS:  if (s_cs_n) state <= IDLE;
                 else if (phi2_fall) state <= COMMIT;
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [2:0]      voice_hit;
  logic [2:0][2:0] voice_off;
  logic [4:0]      vdiff [NUM_VOICES];
  logic [4:0]      fdiff;
  logic            filt_hit;
  logic [1:0]      filt_idx;

  // Out-of-range addresses wrap the 5-bit difference past the stride, so one compare suffices.
  always_comb begin
    voice_hit = '0;
    voice_off = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      vdiff[v]     = addr_q - 5'(v * VOICE_STRIDE);
      voice_hit[v] = vdiff[v] < 5'(VOICE_STRIDE);
      voice_off[v] = vdiff[v][2:0];
    end
    fdiff    = addr_q - REG_FC_LO;
    filt_hit = fdiff < 5'(NUM_FILT);
    filt_idx = fdiff[1:0];
  end

  voice_regs_t [NUM_VOICES-1:0] voice;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voice       <= '0;
      filt        <= '0;
      ctrl_wr_stb <= '0;
    end else begin
      ctrl_wr_stb <= '0;
      if (commit_wr) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_hit[v]) voice[v] <= voice_write(voice[v], voice_off[v], data_q);
          ctrl_wr_stb[v] <= voice_hit[v] && (voice_off[v] == 3'(REG_V1_CONTROL));
        end
        if (filt_hit) filt[filt_idx] <= data_q;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      freq[v]    = voice[v].freq;
      pw[v]      = voice[v].pw;
      control[v] = voice[v].control;
      adsr[v]    = {voice[v].ad, voice[v].sr};
    end
  end

  logic [7:0] rb_latch;

`ifdef SID_READBACK_DECAY_EN
  logic [31:0] decay_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_latch  <= '0;
      decay_cnt <= '0;
    end else if (commit_wr) begin
      rb_latch  <= data_q;
      decay_cnt <= 32'(DECAY_CYCLES);
    end else if (decay_cnt != 32'd0) begin
      decay_cnt <= decay_cnt - 32'd1;
      if (decay_cnt == 32'd1) rb_latch <= '0;
    end
  end
`else
  assign rb_latch = 8'h00;
`endif

  logic [7:0] rd_mux;

  always_comb begin
    case (addr_q)
      REG_POTX: rd_mux = potx;
      REG_POTY: rd_mux = poty;
      REG_OSC3: rd_mux = osc3;
      REG_ENV3: rd_mux = env3;
      default:  rd_mux = rb_latch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_out <= '0;
    else if (state == ACCESS && s_rw) data_out <= rd_mux;
  end

  assign data_oe = ((state == ACCESS) && s_rw) || ((state == COMMIT) && rw_lat);

endmodule

// File: tb/tb_sid_bus_regs.sv
// tb/tb_sid_bus_regs.sv - scoreboard bench for sid_bus_regs (honours SID_READBACK_DECAY_EN)
module tb_sid_bus_regs;

  logic            clk = 1'b0;
  logic            rst;
  logic            phi2, cs_n, rw;
  logic [4:0]      addr;
  logic [7:0]      data_in;
  logic [7:0]      data_out;
  logic            data_oe;
  logic [2:0][15:0] freq;
  logic [2:0][11:0] pw;
  logic [2:0][7:0]  control;
  logic [2:0][15:0] adsr;
  logic [2:0]       ctrl_wr_stb;
  logic [3:0][7:0]  filt;
  logic [7:0]      osc3, env3, potx, poty;

  always #5 clk = ~clk;

  sid_bus_regs #(
    .SYNC_STAGES(2)
`ifdef SID_READBACK_DECAY_EN
    , .DECAY_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .phi2(phi2), .cs_n(cs_n), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .freq(freq),
    .pw(pw), .control(control), .adsr(adsr), .ctrl_wr_stb(ctrl_wr_stb),
    .filt(filt), .osc3(osc3), .env3(env3), .potx(potx), .poty(poty)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0] m [32];
  logic [7:0] rd_q [$];
  int         stb_v_q [$];
  logic [7:0] stb_d_q [$];
  bit         decay_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 8'h00;
  endtask

  task automatic check_state();
    @(negedge clk);
    for (int v = 0; v < 3; v++) begin
      chk($sformatf("freq%0d", v), 32'(freq[v]), 32'({m[7*v+1], m[7*v]}));
      chk($sformatf("pw%0d", v), 32'(pw[v]), 32'({m[7*v+3][3:0], m[7*v+2]}));
      chk($sformatf("control%0d", v), 32'(control[v]), 32'(m[7*v+4]));
      chk($sformatf("adsr%0d", v), 32'(adsr[v]), 32'({m[7*v+5], m[7*v+6]}));
    end
    for (int i = 0; i < 4; i++) chk($sformatf("filt%0d", i), 32'(filt[i]), 32'(m[21+i]));
  endtask

  // One complete bus cycle; abort releases cs_n while phi2 is still high.
  task automatic bus(input bit rd, input logic [4:0] a, input logic [7:0] d, input bit abort);
    cs_n = 1'b0; rw = rd; addr = a; data_in = d;
    tick(2);
    phi2 = 1'b1;
    tick(4);
    if (rd) begin
      @(negedge clk);
      chk("oe_in_access", 32'(data_oe), 32'd1);
    end
    tick(1);
    if (abort) begin
      cs_n = 1'b1;
      tick(3);
    end
    phi2 = 1'b0;
    tick(5);
    cs_n = 1'b1; rw = 1'b1;
    tick(2);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    if (a == 5'h04 || a == 5'h0B || a == 5'h12) begin
      stb_v_q.push_back(int'(a) / 7);
      stb_d_q.push_back(d);
    end
    if (a <= 5'h18) m[a] = d;
    bus(1'b0, a, d, 1'b0);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus(1'b1, a, 8'h00, 1'b0);
  endtask

  function automatic logic [7:0] live_src(input logic [4:0] a);
    case (a)
      5'h19: return potx;
      5'h1A: return poty;
      5'h1B: return osc3;
      5'h1C: return env3;
      default: return 8'h00;
    endcase
  endfunction

  logic prev_oe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_oe = 1'b0;
    end else begin
      if (prev_oe && !data_oe) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", 32'(data_out), 32'(rd_q.pop_front()));
      end
      prev_oe = data_oe;
      if (ctrl_wr_stb != 3'b000) begin
        if (stb_v_q.size() == 0) begin
          chk("stb_unexpected", 32'(ctrl_wr_stb), 32'd0);
        end else begin
          int v;
          logic [7:0] d;
          v = stb_v_q.pop_front();
          d = stb_d_q.pop_front();
          chk("stb_vec", 32'(ctrl_wr_stb), 32'(1 << v));
          chk("stb_ctrl", 32'(control[v]), 32'(d));
        end
      end
    end
  end

  initial begin
`ifdef SID_READBACK_DECAY_EN
    decay_mode = 1'b1;
`else
    decay_mode = 1'b0;
`endif
    rst = 1'b0; phi2 = 1'b0; cs_n = 1'b1; rw = 1'b1; addr = '0; data_in = '0;
    osc3 = 8'h00; env3 = 8'h00; potx = 8'h00; poty = 8'h00;
    model_clear();
    tick(5);
    check_state();
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_stb", 32'(ctrl_wr_stb), 32'd0);
    rst = 1'b1;
    tick(5);

    do_write(5'h04, 8'h01);
    check_state();

    do_write(5'h05, 8'hFF);
    do_write(5'h06, 8'h8F);
    check_state();
    chk("adsr0_value", 32'(adsr[0]), 32'h0000FF8F);

    env3 = 8'h5A;
    do_read(5'h1C, 8'h5A);
    do_write(5'h1C, 8'h77);
    check_state();
    do_read(5'h1C, 8'h5A);

    bus(1'b0, 5'h0B, 8'h55, 1'b1);
    tick(4);
    check_state();

    do_write(5'h00, 8'hA5);
    do_read(5'h00, decay_mode ? 8'hA5 : 8'h00);
    tick(40);
    do_read(5'h00, 8'h00);
    check_state();

    for (int n = 0; n < 60; n++) begin
      logic [4:0] a;
      logic [7:0] d;
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      osc3 = 8'($urandom); env3 = 8'($urandom);
      potx = 8'($urandom); poty = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, d);
      end else begin
        if (decay_mode && (a < 5'h19 || a > 5'h1C)) tick(40);
        do_read(a, live_src(a));
      end
      if (n % 10 == 9) check_state();
    end

    cs_n = 1'b0; rw = 1'b0; addr = 5'h12; data_in = 8'h41;
    tick(2);
    phi2 = 1'b1;
    tick(4);
    rst = 1'b0;
    model_clear();
    tick(2);
    check_state();
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_data_oe", 32'(data_oe), 32'd0);
    chk("midrst_stb", 32'(ctrl_wr_stb), 32'd0);
    rst = 1'b1;
    tick(4);
    phi2 = 1'b0;
    tick(5);
    cs_n = 1'b1; rw = 1'b1;
    tick(6);
    check_state();
    chk("midrst_control2", 32'(control[2]), 32'd0);

    tick(10);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("stb_queue_drained", 32'(stb_v_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
